// File: rtl/mm_pkg.sv
// Shared encodings for the line-burst memory: request opcodes and FSM states.
package mm_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SWAP  = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WBEAT = 2'b01,
    WAIT  = 2'b10,
    RBEAT = 2'b11
  } state_t;

endpackage

// File: rtl/mm_array.sv
// Single-port word storage: synchronous write, combinational read, zero at power-up.
module mm_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Power-up contents come from the declaration; reset deliberately never touches storage.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mm_burst.sv
// Line-granular burst engine: read, write or swap (victim write-back then fill read) of one cache line.
module mm_burst
  import mm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int LAT        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_victim,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy
);

  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [OFF-1:0]   LAST_BEAT = OFF'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_END   = LAT_W'(LAT - 1);

  state_t            state, next_state;
  op_t               op_in, op_reg;
  logic [ADDR_W-1:0] fill_base, victim_base, line_base, mem_addr;
  logic [OFF-1:0]    beat;
  logic [LAT_W-1:0]  lat_cnt;
  logic              accept, mem_we, rd_issue;
  logic [DATA_W-1:0] mem_rdata;

  assign op_in  = op_t'(req_op);
  assign accept = req_valid && (state == IDLE) && (op_in != OP_NOP);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (op_in)
            OP_READ:           next_state = WAIT;
            OP_WRITE, OP_SWAP: next_state = WBEAT;
            default:           next_state = IDLE;
          endcase
        end
      end
      WBEAT: begin
        if (wr_valid && beat == LAST_BEAT)
          next_state = (op_reg == OP_SWAP) ? WAIT : IDLE;
      end
      WAIT: begin
        if (lat_cnt == LAT_END) next_state = RBEAT;
      end
      RBEAT: begin
        if (beat == LAST_BEAT) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    req_ready = (state == IDLE);
    wr_ready  = (state == WBEAT);
    busy      = (state != IDLE);
    mem_we    = (state == WBEAT) && wr_valid;
    rd_issue  = (state == RBEAT);
    line_base = (state == WBEAT && op_reg == OP_SWAP) ? victim_base : fill_base;
    // Beat replaces the offset bits outright, so the address can never carry out of the line.
    mem_addr  = {line_base[ADDR_W-1:OFF], beat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= OP_NOP;
      fill_base   <= '0;
      victim_base <= '0;
      beat        <= '0;
      lat_cnt     <= '0;
    end else begin
      if (accept) begin
        op_reg      <= op_in;
        fill_base   <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
        victim_base <= {req_victim[ADDR_W-1:OFF], {OFF{1'b0}}};
        beat        <= '0;
        lat_cnt     <= '0;
      end
      if (mem_we || rd_issue) beat <= beat + 1'b1;
      if (state == WAIT) lat_cnt <= (lat_cnt == LAT_END) ? '0 : lat_cnt + 1'b1;
    end
  end

  // Read beats are registered, so rd_valid trails RBEAT by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_issue;
      rd_last  <= rd_issue && (beat == LAST_BEAT);
      rd_data  <= rd_issue ? mem_rdata : '0;
    end
  end

  mm_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wr_data),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mm_burst.sv
// Directed bench for mm_burst: line write/read/swap, stalled writes, mid-burst reset, ignored requests.
module tb_mm_burst;

  localparam int LAT = 3;
  localparam int LW  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_victim;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] line_a [4];
  logic [7:0] line_b [4];
  logic [7:0] line_c [4];
  logic [7:0] line_d [4];
  logic [7:0] line_z [4];

  always #5 clk = ~clk;

  mm_burst #(.DATA_W(8), .ADDR_W(8), .LINE_WORDS(LW), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_victim (req_victim),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .busy       (busy)
  );

  // Checks the LAT+LW+1 cycles after a read is launched (accept edge or last write edge).
  // If drop is set, req_valid/wr_valid are released on the cycle rd_last shows.
  task automatic rd_window(input string tag, input logic [7:0] e [4], input bit drop);
    logic       ev, el, eb;
    logic [7:0] ed;
    for (int k = 1; k <= LAT + LW + 1; k++) begin
      @(posedge clk); #1;
      ev = (k >= LAT + 1) && (k <= LAT + LW);
      el = (k == LAT + LW);
      eb = (k < LAT + LW);
      ed = ev ? e[k - LAT - 1] : 8'h00;
      checks++;
      if (rd_valid !== ev || rd_data !== ed || rd_last !== el || busy !== eb) begin
        errors++;
        $display("FAIL %s cyc%0d valid/data/last/busy got %b/%h/%b/%b need %b/%h/%b/%b",
                 tag, k, rd_valid, rd_data, rd_last, busy, ev, ed, el, eb);
      end
      if (drop && el) begin
        req_valid = 1'b0;
        wr_valid  = 1'b0;
      end
    end
    checks++;
    if (req_ready !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s end req_ready/wr_ready got %b/%b need 1/0", tag, req_ready, wr_ready);
    end
    $display("txn %s read done", tag);
  endtask

  task automatic read_line(input string tag, input logic [7:0] a, input logic [7:0] e [4]);
    req_valid = 1'b1; req_op = 2'b00; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd_window(tag, e, 1'b0);
  endtask

  task automatic write_line(input string tag, input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] v, input logic [7:0] d [4],
                            input logic [7:0] fill [4], input bit gap);
    req_valid = 1'b1; req_op = op; req_addr = a; req_victim = v;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept wr_ready/busy got %b/%b need 1/1", tag, wr_ready, busy);
    end
    for (int b = 0; b < LW; b++) begin
      if (gap && b == 2) begin
        wr_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
          @(posedge clk); #1;
          checks++;
          if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s gap%0d wr_ready got %b need 1", tag, g, wr_ready);
          end
        end
      end
      wr_valid = 1'b1; wr_data = d[b];
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    if (op == 2'b01) begin
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s done busy/req_ready/wr_ready got %b/%b/%b need 0/1/0",
                 tag, busy, req_ready, wr_ready);
      end
      $display("txn %s write done", tag);
    end else begin
      checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s swap-wait wr_ready/busy got %b/%b need 0/1", tag, wr_ready, busy);
      end
      rd_window(tag, fill, 1'b0);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
        busy !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset rdy/wrdy/rv/rl/busy/rd got %b/%b/%b/%b/%b/%h need 1/0/0/0/0/00",
               req_ready, wr_ready, rd_valid, rd_last, busy, rd_data);
    end
    $display("txn reset checked");
  endtask

  task automatic test_write_read;
    write_line("write_10", 2'b01, 8'h10, 8'h00, line_a, line_z, 1'b0);
    read_line("read_12", 8'h12, line_a);
  endtask

  task automatic test_swap;
    write_line("swap_20_10", 2'b10, 8'h10, 8'h20, line_b, line_a, 1'b0);
    read_line("read_20", 8'h23, line_b);
    read_line("read_10", 8'h10, line_a);
    // Victim and fill share the 0x50 line: new data must come back.
    write_line("swap_same", 2'b10, 8'h52, 8'h51, line_c, line_c, 1'b0);
  endtask

  task automatic test_write_gap;
    write_line("write_gap_40", 2'b01, 8'h41, 8'h00, line_d, line_z, 1'b1);
    read_line("read_40", 8'h40, line_d);
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_op = 2'b00; req_addr = 8'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hBB) begin
      errors++;
      $display("FAIL rst_mid beat1 valid/data got %b/%h need 1/bb", rd_valid, rd_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || rd_last !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async rv/rd/rl/busy/rdy/wrdy got %b/%h/%b/%b/%b/%b need 0/00/0/0/1/0",
               rd_valid, rd_data, rd_last, busy, req_ready, wr_ready);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    $display("txn rst_mid reset applied");
    read_line("read_after_rst", 8'h10, line_a);
  endtask

  task automatic test_ignored;
    // Read 0x10 while a write request to 0x30 and stray write beats are held the whole time.
    req_valid = 1'b1; req_op = 2'b00; req_addr = 8'h10;
    @(posedge clk); #1;
    req_op = 2'b01; req_addr = 8'h30; wr_valid = 1'b1; wr_data = 8'hEE;
    rd_window("hold_busy", line_a, 1'b1);
    read_line("read_30", 8'h30, line_z);
    req_valid = 1'b1; req_op = 2'b11; req_addr = 8'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL nop busy/rdy/wrdy/rv got %b/%b/%b/%b need 0/1/0/0",
               busy, req_ready, wr_ready, rd_valid);
    end
    $display("txn nop checked");
    read_line("read_10_after_nop", 8'h10, line_a);
  endtask

  initial begin
    line_a = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    line_b = '{8'h11, 8'h12, 8'h13, 8'h14};
    line_c = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    line_d = '{8'h01, 8'h02, 8'h03, 8'h04};
    line_z = '{8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b11; req_addr = 8'h00; req_victim = 8'h00;
    wr_data = 8'h00; wr_valid = 1'b0;
    #1;
    test_reset;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    read_line("read_zero_30", 8'h30, line_z);
    test_write_read;
    test_swap;
    test_write_gap;
    test_reset_mid;
    test_ignored;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_burst.md
MM_BURST -- requirements
Module: mm_burst

Interface
REQ-001 Parameter DATA_W, default 8: width of one memory word in bits.
REQ-002 Parameter ADDR_W, default 8: word address width; depth is 2**ADDR_W words.
REQ-003 Parameter LINE_WORDS, default 4: words per cache line; power of two, at least 2.
REQ-004 Parameter LAT, default 3: access latency in cycles; at least 1.
REQ-005 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-006 Port rst  in  1: asynchronous, active-high reset.
REQ-007 Port req_valid  in  1: a request is presented.
REQ-008 Port req_ready  out  1: block is idle and can accept a request.
REQ-009 Port req_op  in  2: 00 read line, 01 write line, 10 swap (write back victim line, then read fill line), 11 no-op.
REQ-010 Port req_addr  in  ADDR_W: fill or write line address.
REQ-011 Port req_victim  in  ADDR_W: victim line address; used only for swap.
REQ-012 Port wr_data  in  DATA_W: write-beat data.
REQ-013 Port wr_valid  in  1: write beat is presented.
REQ-014 Port wr_ready  out  1: block can accept a write beat.
REQ-015 Port rd_data  out  DATA_W: read-beat data.
REQ-016 Port rd_valid  out  1: rd_data is valid this cycle; there is no backpressure.
REQ-017 Port rd_last  out  1: marks the final beat of a line.
REQ-018 Port busy  out  1: high whenever the block is not in the IDLE state.

Function
REQ-019 The FSM SHALL have the states IDLE, WBEAT, WAIT and RBEAT; req_ready SHALL equal (state==IDLE).
REQ-020 A request SHALL be accepted on an edge where req_valid and req_ready are both high; req_addr and req_victim are captured with their low log2(LINE_WORDS) bits forced to zero.
REQ-021 On acceptance, op read SHALL go to WAIT, op write and op swap SHALL go to WBEAT, and op no-op SHALL stay in IDLE with no effect.
REQ-022 WBEAT SHALL hold wr_ready high; each wr_valid&&wr_ready edge SHALL write MEM[base+beat], where base is the victim address for swap and the captured address for write.
REQ-023 The beat counter SHALL increment on each write and stall when wr_valid is low; after beat LINE_WORDS-1, write SHALL go to IDLE and swap SHALL go to WAIT.
REQ-024 WAIT SHALL last exactly LAT cycles, then go to RBEAT.
REQ-025 RBEAT SHALL drive rd_valid high for LINE_WORDS consecutive cycles with rd_data=MEM[base+beat], in ascending beat order, and rd_last high on the final beat only; the state then goes to IDLE.
REQ-026 For a read accepted at edge E0, rd_valid SHALL be high in the cycles following edges E(LAT+1) through E(LAT+LINE_WORDS).
REQ-027 A swap with victim equal to fill SHALL return the newly written data.
REQ-028 The address sum base+beat SHALL stay inside the line and never carry into upper address bits.
REQ-029 Requests presented while busy SHALL be ignored and not queued; wr_valid outside WBEAT SHALL be ignored.
REQ-030 rd_data SHALL be 0 whenever rd_valid is low.

Reset
REQ-031 rst SHALL immediately force IDLE, beat and latency counters to 0, and req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, busy=0, rd_data=0.
REQ-032 Memory contents SHALL be 0 at time zero and SHALL NOT be cleared by rst; words written before a mid-operation reset SHALL be retained.

Structure
REQ-033 Package mm_pkg SHALL hold the op encodings and the FSM state enumeration.
REQ-034 Storage SHALL be the sub-module mm_array: single port, synchronous write, combinational read, parameterised by DATA_W and ADDR_W.

Verification
REQ-035 Write line 0x10 with AA,BB,CC,DD, then read 0x12 -> beats AA,BB,CC,DD from 0x10, with the first rd_valid 4 cycles after accept (LAT=3) and rd_last on DD.
REQ-036 Swap with victim 0x20 (data 11..14) and fill 0x10 -> 0x20..0x23 hold 11..14, then reads return AA..DD.
REQ-037 Write with wr_valid low for 2 cycles between beats 1 and 2 -> all 4 words correct, no skipped or doubled beat.
REQ-038 Assert rst during RBEAT beat 1 -> outputs zero immediately, req_ready=1, and a following read returns an intact line.
REQ-039 Hold req_valid high while busy, and issue op 11 in IDLE -> no second transaction and no memory change.
